// File: rtl/batch_controller.sv
// Sequencing FSM for the read -> register -> operate -> write datapath.
// Loads BATCH words per operation and runs NBATCH operations per start request.
module batch_controller #(
    parameter int ADDR_W = 6,
    parameter int IDX_W  = 3,
    parameter int BATCH  = 8,
    parameter int NBATCH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic              mem_valid,
    input  logic              op_done,
    output logic [ADDR_W-1:0] AddrReading,
    output logic [ADDR_W-1:0] AddrWriting,
    output logic [IDX_W-1:0]  RegIndex,
    output logic              EnableInputMEM,
    output logic              EnableReg,
    output logic              EnableOperation,
    output logic              EnableOutputMEM,
    output logic              Done,
    output logic              Busy
);

    localparam int BATCH_W = $clog2(NBATCH) + 1;
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(BATCH - 1);
    localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(NBATCH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WREG = 3'd2,
        OPER = 3'd3,
        WMEM = 3'd4,
        DONE = 3'd5
    } stateT;

    stateT              state;
    logic [BATCH_W-1:0] batchCnt;

    // NOTE: every register below is updated with <= so all of them see the
    // pre-edge values of state and counters, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            AddrReading <= '0;
            AddrWriting <= '0;
            RegIndex    <= '0;
            batchCnt    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        AddrReading <= in_base;
                        AddrWriting <= out_base;
                        RegIndex    <= '0;
                        batchCnt    <= '0;
                        state       <= READ;
                    end
                end
                READ: state <= WREG;
                WREG: begin
                    if (mem_valid) begin
                        AddrReading <= AddrReading + ADDR_W'(1);
                        if (RegIndex == LAST_IDX) begin
                            state <= OPER;
                        end else begin
                            RegIndex <= RegIndex + IDX_W'(1);
                            state    <= READ;
                        end
                    end
                end
                OPER: begin
                    if (op_done) state <= WMEM;
                end
                WMEM: begin
                    if (batchCnt == LAST_BATCH) begin
                        state <= DONE;
                    end else begin
                        // Next batch starts immediately; reads stay contiguous.
                        batchCnt    <= batchCnt + BATCH_W'(1);
                        AddrWriting <= AddrWriting + ADDR_W'(1);
                        RegIndex    <= '0;
                        state       <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs straight from the state register; EnableReg alone also
    // follows mem_valid so a stalled WREG never writes the register file.
    assign EnableInputMEM  = (state == READ);
    assign EnableReg       = (state == WREG) && mem_valid;
    assign EnableOperation = (state == OPER);
    assign EnableOutputMEM = (state == WMEM);
    assign Done            = (state == DONE);
    assign Busy            = (state == READ) || (state == WREG) ||
                             (state == OPER) || (state == WMEM);

endmodule

// File: tb/tb_batch_controller.sv
// Self-checking bench for batch_controller: table of full runs plus
// hand-written reset and restart sequences.
module tb_batch_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] in_base;
    logic [5:0] out_base;
    logic       mem_valid;
    logic       op_done;
    logic [5:0] AddrReading;
    logic [5:0] AddrWriting;
    logic [2:0] RegIndex;
    logic       EnableInputMEM;
    logic       EnableReg;
    logic       EnableOperation;
    logic       EnableOutputMEM;
    logic       Done;
    logic       Busy;

    int checks   = 0;
    int failures = 0;

    batch_controller #(
        .ADDR_W(6), .IDX_W(3), .BATCH(8), .NBATCH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_base(in_base), .out_base(out_base),
        .mem_valid(mem_valid), .op_done(op_done),
        .AddrReading(AddrReading), .AddrWriting(AddrWriting),
        .RegIndex(RegIndex),
        .EnableInputMEM(EnableInputMEM), .EnableReg(EnableReg),
        .EnableOperation(EnableOperation), .EnableOutputMEM(EnableOutputMEM),
        .Done(Done), .Busy(Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] inBase;
        logic [5:0] outBase;
        int         stallW;     // mem_valid low cycles in the first WREG
        int         stallO;     // op_done low cycles at the start of each OPER
        int         busyStart;  // cycle in which start is pulsed while Busy (0 = none)
        int         expDone;    // first cycle with Done=1, start edge = cycle 0
    } runVecT;

    function automatic logic [31:0] allOutputs();
        return {11'd0, AddrReading, AddrWriting, RegIndex, EnableInputMEM, EnableReg,
                EnableOperation, EnableOutputMEM, Done, Busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One complete run; the bench model tracks the expected read/write
    // address streams from the bases and counts every enable pulse.
    task automatic runSeq(input runVecT v, input int row);
        logic [5:0] expRd;
        logic [5:0] expWr;
        logic [2:0] expIdx;
        int c, operRun, regPulses, wrPulses, operCycles, doneCycle, postCnt;
        int seqErr, wrErr, xErr, stallErr, busyErr, multiErr, postErr;
        expRd = v.inBase; expWr = v.outBase; expIdx = '0;
        operRun = 0; regPulses = 0; wrPulses = 0; operCycles = 0; doneCycle = 0; postCnt = 0;
        seqErr = 0; wrErr = 0; xErr = 0; stallErr = 0; busyErr = 0; multiErr = 0; postErr = 0;

        @(negedge clk);
        in_base = v.inBase; out_base = v.outBase; start = 1'b1;
        mem_valid = 1'b1; op_done = 1'b0;
        @(posedge clk);
        c = 1;
        while (c < 400 && postCnt < 3) begin
            @(negedge clk);
            start    = (c == v.busyStart);
            in_base  = v.inBase ^ 6'h2A;   // bases must already be latched
            out_base = v.outBase ^ 6'h15;
            mem_valid = !(c >= 2 && c < 2 + v.stallW);
            op_done   = EnableOperation && (operRun >= v.stallO);
            #1;
            if ($isunknown(allOutputs())) xErr++;
            if ($countones({EnableInputMEM, EnableReg, EnableOperation, EnableOutputMEM}) > 1)
                multiErr++;
            if (!mem_valid && (EnableInputMEM || EnableReg || EnableOperation || EnableOutputMEM))
                stallErr++;
            if (EnableReg) begin
                if (AddrReading !== expRd || RegIndex !== expIdx) seqErr++;
                expRd  = expRd + 6'd1;
                expIdx = expIdx + 3'd1;
                regPulses++;
            end
            if (EnableOutputMEM) begin
                if (AddrWriting !== expWr) wrErr++;
                expWr = expWr + 6'd1;
                wrPulses++;
            end
            if (EnableOperation) begin
                operCycles++;
                operRun++;
            end else begin
                operRun = 0;
            end
            if (doneCycle == 0) begin
                if (Done) begin
                    doneCycle = c;
                    if (Busy) busyErr++;
                end else if (!Busy) begin
                    busyErr++;
                end
            end else begin
                postCnt++;
                if (!(Done && !Busy)) postErr++;
            end
            c++;
        end

        check($sformatf("r%0d_done_cycle", row), doneCycle, v.expDone);
        check($sformatf("r%0d_enable_reg_pulses", row), regPulses, 64);
        check($sformatf("r%0d_read_stream_errors", row), seqErr, 0);
        check($sformatf("r%0d_write_pulses", row), wrPulses, 8);
        check($sformatf("r%0d_write_addr_errors", row), wrErr, 0);
        check($sformatf("r%0d_oper_cycles", row), operCycles, 8 * (v.stallO + 1));
        check($sformatf("r%0d_stall_enable_errors", row), stallErr, 0);
        check($sformatf("r%0d_busy_errors", row), busyErr, 0);
        check($sformatf("r%0d_multi_enable", row), multiErr, 0);
        check($sformatf("r%0d_x_outputs", row), xErr, 0);
        check($sformatf("r%0d_post_done", row), postErr, 0);
        check($sformatf("r%0d_final_read_addr", row), AddrReading, v.inBase);
        check($sformatf("r%0d_final_write_addr", row), AddrWriting, 32'(6'(v.outBase + 6'd7)));
    endtask

    // Abort a run in the OPER state of batch 3 with an asynchronous reset.
    task automatic resetMidOper();
        int wr;
        bit found;
        wr = 0; found = 1'b0;
        @(negedge clk);
        in_base = 6'd5; out_base = 6'd9; start = 1'b1; mem_valid = 1'b1; op_done = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start   = 1'b0;
            op_done = (wr < 3);
            #1;
            if (wr == 3 && EnableOperation) begin
                found = 1'b1;
                break;
            end
            if (EnableOutputMEM) wr++;
        end
        check("reached_oper_batch3", found, 1'b1);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", allOutputs(), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 check("held_reset_outputs", allOutputs(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("after_release_idle", allOutputs(), 32'd0);
    endtask

    runVecT vecs[5];
    runVecT postReset;

    initial begin
        vecs[0] = '{6'd0,  6'd0,  0, 0, 0,  145};
        vecs[1] = '{6'd60, 6'd62, 0, 0, 0,  145};
        vecs[2] = '{6'd0,  6'd0,  3, 0, 0,  148};
        vecs[3] = '{6'd0,  6'd0,  0, 5, 0,  185};
        vecs[4] = '{6'd17, 6'd40, 2, 1, 20, 155};
        postReset = '{6'd33, 6'd50, 0, 0, 0, 145};

        rst = 1'b0; start = 1'b0; in_base = '0; out_base = '0;
        mem_valid = 1'b0; op_done = 1'b0;
        #12 check("reset_outputs", allOutputs(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 check("idle_outputs", allOutputs(), 32'd0);

        // Row 0 starts from IDLE; each later row restarts from DONE.
        for (int i = 0; i < 5; i++) runSeq(vecs[i], i);

        resetMidOper();
        runSeq(postReset, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/batch_controller.md
# batch_controller

Parameterised sequencing FSM for the read→register→operate→write datapath. It gathers BATCH words from input memory into the register file one index at a time, fires the operation unit, writes one result to output memory, and repeats for NBATCH batches before flagging completion. Compared with the fixed 8×8 controller, it adds run-time base addresses, a start/busy handshake, memory-valid and operation-done stalls, and restart from DONE without reset.

## Interface
- ADDR_W, 6, width of read and write address counters
- IDX_W, 3, width of RegIndex; BATCH ≤ 2^IDX_W required
- BATCH, 8, words loaded per operation (≥1)
- NBATCH, 8, operations per run (≥1); internal batch counter is $clog2(NBATCH)+1 bits

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE or DONE
- in_base  in  ADDR_W  first read address, latched on accepted start
- out_base  in  ADDR_W  first write address, latched on accepted start
- mem_valid  in  1  input-memory read data valid
- op_done  in  1  operation unit finished
- AddrReading  out  ADDR_W  input-memory read address
- AddrWriting  out  ADDR_W  output-memory write address
- RegIndex  out  IDX_W  register-file write index
- EnableInputMEM  out  1  input-memory read enable
- EnableReg  out  1  register-file write enable
- EnableOperation  out  1  operation unit enable
- EnableOutputMEM  out  1  output-memory write enable
- Done  out  1  run complete
- Busy  out  1  run in progress

## Operation
- States: IDLE, READ, WREG, OPER, WMEM, DONE.
- IDLE: all enables 0. On start: AddrReading←in_base, AddrWriting←out_base, RegIndex←0, batch←0, go to READ.
- READ: EnableInputMEM=1 for one cycle, then go to WREG.
- WREG: EnableReg=mem_valid; this is the only Mealy output. With mem_valid=0, stay in WREG with all enables 0 except EnableReg=0. With mem_valid=1: AddrReading+1. If RegIndex==BATCH-1, go to OPER. Otherwise RegIndex+1 and go to READ.
- OPER: EnableOperation=1 every cycle in the state. When op_done=1, go to WMEM. op_done in the first OPER cycle is honoured.
- WMEM: EnableOutputMEM=1 for one cycle. If batch==NBATCH-1, go to DONE. Otherwise batch+1, AddrWriting+1, RegIndex←0, go to READ. There is no idle cycle between batches.
- DONE: Done=1, enables 0. Addresses hold their final values. On start: re-latch the bases, clear the counters, go to READ.
- Busy=1 in READ, WREG, OPER and WMEM; 0 in IDLE and DONE. start is ignored while Busy.
- AddrReading is not reset between batches; reads are contiguous across the whole run.
- Address arithmetic wraps modulo 2^ADDR_W, with no flag.
- Simultaneous start and reset: reset wins.

## Timing
- Reset (rst=0) forces IDLE immediately and asynchronously. All outputs go to 0: addresses, RegIndex, enables, Done and Busy.
- Reset mid-run aborts with no further enables. Release resumes in IDLE.
- Registered state. All outputs except EnableReg are decoded from state and counters only.
- Zero-stall batch length (mem_valid=1, op_done=1): 2·BATCH+2 cycles. Default is 18.
- Zero-stall run: start sampled at edge 0 puts READ in cycle 1. The last WMEM is in cycle NBATCH·(2·BATCH+2), which is 144 by default. Done rises in cycle 145.
- Each WREG cycle with mem_valid=0 adds one cycle. Each OPER cycle with op_done=0 adds one cycle.

## Test plan
- Defaults, in_base=0, out_base=0, mem_valid=op_done=1, start pulse:
  - EnableReg pulses 64 times, with RegIndex cycling 0..7.
  - AddrReading ends at 64 mod 64 = 0.
  - EnableOutputMEM pulses 8 times at AddrWriting 0..7.
  - Done=1 at cycle 145; Busy=0 from then on.
- in_base=60, out_base=62:
  - Reads go through addresses 60,61,62,63,0,1,…
  - Writes go to 62,63,0,…,5.
  - No X on any output.
- mem_valid low for 3 cycles in the first WREG: FSM stays in WREG and EnableReg=0 during the stall. Run completes at cycle 148.
- op_done held low for 5 cycles in each OPER: EnableOperation stays high for 6 cycles per batch. Done at cycle 185.
- rst=0 asynchronously mid-OPER of batch 3: all outputs 0 within the same cycle. After release, start with new bases runs a full clean sequence.
- start pulsed while Busy: ignored, with no change to the addresses. start in DONE restarts the run, and Done falls the next cycle.
